// File: rtl/cmn_fifo_hs.sv
// cmn_fifo_hs: synchronous FIFO with valid/ready handshake on both sides and
// first-word-fall-through read.
//
// The storage array is inferred in-module. Occupancy is derived from the
// pointers, so level and the almost flags depend only on registered state and
// on the threshold inputs.
//
// Optional error flags: define CMN_FIFO_HS_ERR_EN to build the sticky
// overflow/underflow flags. Without it, ovf/udf are tied to 0 and the port
// list is unchanged.
//
// Parameters:
//   DW        data width in bits (>=1)
//   AW        address width, depth = 2**AW (>=1)
//
// Ports:
//   clk       clock, all logic on the rising edge
//   rstn      asynchronous active-low reset
//   flush     synchronous clear of the FIFO contents and error flags
//   in_valid  producer has data
//   in_data   write data
//   in_ready  FIFO can accept (not full)
//   out_valid head entry valid (not empty)
//   out_data  head entry data (fall-through)
//   out_ready consumer accepts head
//   level     occupancy, 0..2**AW
//   afull_th  almost-full threshold,  afull  = level >= afull_th
//   aempty_th almost-empty threshold, aempty = level <= aempty_th
//   ovf       sticky overflow  (push attempted while full)
//   udf       sticky underflow (pop attempted while empty)

module cmn_fifo_hs #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [AW:0]   level,
  input  logic [AW:0]   afull_th,
  input  logic [AW:0]   aempty_th,
  output logic          afull,
  output logic          aempty,
  output logic          ovf,
  output logic          udf
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  // Storage: not reset; contents only become visible through out_data once
  // the read pointer lands on an entry that has been written.
  logic [DW-1:0] r_mem [Depth];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [AW:0] w_wptr_d;
  logic [AW:0] w_rptr_d;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  // ---------------------------------------------------------------------------
  // Status decode (state only, no path from in_valid/out_ready)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_empty = (r_wptr == r_rptr);
    w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  end

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;

  // Modular subtraction covers every wrap case, including a full FIFO.
  assign level = r_wptr - r_rptr;

  assign afull  = (level >= afull_th);
  assign aempty = (level <= aempty_th);

  // ---------------------------------------------------------------------------
  // Handshake qualification; flush suppresses both transfers in its cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_push = in_valid  & ~w_full  & ~flush;
    w_pop  = out_ready & ~w_empty & ~flush;
  end

  // ---------------------------------------------------------------------------
  // Pointer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wptr_d = r_wptr;
    w_rptr_d = r_rptr;
    if (flush) begin
      w_wptr_d = '0;
      w_rptr_d = '0;
    end else begin
      if (w_push) begin
        w_wptr_d = r_wptr + PtrOne;
      end
      if (w_pop) begin
        w_rptr_d = r_rptr + PtrOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= w_wptr_d;
      r_rptr <= w_rptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage write and fall-through read
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= in_data;
    end
  end

  // No same-cycle bypass: a word written this cycle is seen next cycle.
  assign out_data = r_mem[r_rptr[AW-1:0]];

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
`ifdef CMN_FIFO_HS_ERR_EN
  logic r_ovf;
  logic r_udf;
  logic w_ovf_d;
  logic w_udf_d;

  // Flush wins over a same-cycle error so a flush always leaves clean flags.
  always_comb begin
    w_ovf_d = r_ovf;
    w_udf_d = r_udf;
    if (flush) begin
      w_ovf_d = 1'b0;
      w_udf_d = 1'b0;
    end else begin
      if (in_valid && w_full) begin
        w_ovf_d = 1'b1;
      end
      if (out_ready && w_empty) begin
        w_udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_d;
      r_udf <= w_udf_d;
    end
  end

  assign ovf = r_ovf;
  assign udf = r_udf;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule
